intc_cpu_ack_ctrl: RTL and testbench

//  Per-CPU interrupt dispatch controller placed between the per-CPU selector and the CPU.

---
 rtl/intc_cpu_ack_ctrl.sv | 124 ++++++++++++
 tb/tb_intc_cpu_ack_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/intc_cpu_ack_ctrl.sv
// Per-CPU interrupt dispatch: masks the selected request against SR.I,
// holds it stable toward the CPU, runs the accept handshake and settles.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   sl_req_i        selector request valid
//   sl_level_i[4:0] selector level (16 = NMI/ERR)
//   sl_vec_i[7:0]   selector vector
//   cpu_imask_i     CPU SR.I3:0
//   int_ack_i       CPU accept pulse
//   int_req_o       request to CPU (registered)
//   int_level_o     presented level (registered)
//   int_vec_o       presented vector (registered)
//   intack_all_o    high while settling
//   clr_vld_o       1-cycle source clear pulse
//   clr_vec_o       vector to clear
//
// Optional feature macro: INTC_ACK_PREEMPT_EN
//   defined   -> a strictly higher eligible request replaces the
//                presented one while waiting for accept
//   undefined -> the presented request is frozen until accepted
//                or withdrawn
module intc_cpu_ack_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sl_req_i,
    input  logic [4:0] sl_level_i,
    input  logic [7:0] sl_vec_i,
    input  logic [3:0] cpu_imask_i,
    input  logic       int_ack_i,
    output logic       int_req_o,
    output logic [4:0] int_level_o,
    output logic [7:0] int_vec_o,
    output logic       intack_all_o,
    output logic       clr_vld_o,
    output logic [7:0] clr_vec_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             eligible;
    logic             upgrade;

    // Level 16 always beats a 4-bit mask, so NMI is never masked.
    assign eligible = sl_req_i & (sl_level_i > {1'b0, cpu_imask_i});

`ifdef INTC_ACK_PREEMPT_EN
    assign upgrade = eligible & (sl_level_i > int_level_o);
`else
    assign upgrade = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            int_req_o    <= 1'b0;
            int_level_o  <= '0;
            int_vec_o    <= '0;
            intack_all_o <= 1'b0;
            clr_vld_o    <= 1'b0;
            clr_vec_o    <= '0;
        end else begin
            clr_vld_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (eligible) begin
                        state       <= REQ;
                        int_req_o   <= 1'b1;
                        int_level_o <= sl_level_i;
                        int_vec_o   <= sl_vec_i;
                    end
                end
                REQ: begin
                    // Accept wins over a simultaneous withdrawal.
                    if (int_ack_i) begin
                        state        <= SETTLE;
                        cnt          <= SETTLE_LD;
                        int_req_o    <= 1'b0;
                        intack_all_o <= 1'b1;
                        clr_vld_o    <= 1'b1;
                        clr_vec_o    <= int_vec_o;
                    end else if (!eligible) begin
                        state     <= IDLE;
                        int_req_o <= 1'b0;
                    end else if (upgrade) begin
                        int_level_o <= sl_level_i;
                        int_vec_o   <= sl_vec_i;
                    end
                end
                SETTLE: begin
                    // Exit on the cycle the count hits 1 so the
                    // window is exactly SETTLE_CYC cycles long.
                    if (cnt == CNT_ONE) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        intack_all_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    int_req_o    <= 1'b0;
                    intack_all_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intc_cpu_ack_ctrl.sv
// Bench for intc_cpu_ack_ctrl: directed scenarios then random traffic,
// every cycle compared against a behavioural dispatch model.
module tb_intc_cpu_ack_ctrl;

    localparam int SETTLE_CYC = 2;
`ifdef INTC_ACK_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sl_req_i;
    logic [4:0] sl_level_i;
    logic [7:0] sl_vec_i;
    logic [3:0] cpu_imask_i;
    logic       int_ack_i;
    logic       int_req_o;
    logic [4:0] int_level_o;
    logic [7:0] int_vec_o;
    logic       intack_all_o;
    logic       clr_vld_o;
    logic [7:0] clr_vec_o;

    int errors = 0;
    int checks = 0;

    // Model state: pending request, its level/vector, settle cycles left.
    bit       m_req;
    int       m_lvl;
    int       m_vec;
    int       m_settle;
    bit       m_clr;
    int       m_clrvec;

    intc_cpu_ack_ctrl #(.SETTLE_CYC(SETTLE_CYC), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sl_req_i    (sl_req_i),
        .sl_level_i  (sl_level_i),
        .sl_vec_i    (sl_vec_i),
        .cpu_imask_i (cpu_imask_i),
        .int_ack_i   (int_ack_i),
        .int_req_o   (int_req_o),
        .int_level_o (int_level_o),
        .int_vec_o   (int_vec_o),
        .intack_all_o(intack_all_o),
        .clr_vld_o   (clr_vld_o),
        .clr_vec_o   (clr_vec_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req    = 0;
        m_lvl    = 0;
        m_vec    = 0;
        m_settle = 0;
        m_clr    = 0;
        m_clrvec = 0;
    endtask

    task automatic model_step();
        bit elig;
        elig  = sl_req_i && (int'(sl_level_i) > int'(cpu_imask_i));
        m_clr = 0;
        if (m_settle > 0) begin
            m_settle--;
        end else if (m_req) begin
            if (int_ack_i) begin
                m_req    = 0;
                m_clr    = 1;
                m_clrvec = m_vec;
                m_settle = SETTLE_CYC;
            end else if (!elig) begin
                m_req = 0;
            end else if (PRE && int'(sl_level_i) > m_lvl) begin
                m_lvl = int'(sl_level_i);
                m_vec = int'(sl_vec_i);
            end
        end else if (elig) begin
            m_req = 1;
            m_lvl = int'(sl_level_i);
            m_vec = int'(sl_vec_i);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".req"}, int'(int_req_o), int'(m_req));
        chk({tag, ".lvl"}, int'(int_level_o), m_lvl);
        chk({tag, ".vec"}, int'(int_vec_o), m_vec);
        chk({tag, ".ackall"}, int'(intack_all_o), int'(m_settle > 0));
        chk({tag, ".clr"}, int'(clr_vld_o), int'(m_clr));
        if (m_clr) chk({tag, ".clrvec"}, int'(clr_vec_o), m_clrvec);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        cmp_model(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req"}, int'(int_req_o), 0);
        chk({tag, ".lvl"}, int'(int_level_o), 0);
        chk({tag, ".vec"}, int'(int_vec_o), 0);
        chk({tag, ".ackall"}, int'(intack_all_o), 0);
        chk({tag, ".clr"}, int'(clr_vld_o), 0);
        chk({tag, ".clrvec"}, int'(clr_vec_o), 0);
    endtask

    task automatic drive(input bit r, input int l, input int v,
                         input int m, input bit a);
        sl_req_i    = r;
        sl_level_i  = 5'(l);
        sl_vec_i    = 8'(v);
        cpu_imask_i = 4'(m);
        int_ack_i   = a;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // T1: basic dispatch and settle
        drive(1, 5, 8'h40, 3, 0);
        tick("t1.req");
        chk("t1.lvl5", int'(int_level_o), 5);
        chk("t1.vec40", int'(int_vec_o), 8'h40);
        drive(1, 5, 8'h40, 3, 1);
        tick("t1.ack");
        chk("t1.clrvec40", int'(clr_vec_o), 8'h40);
        drive(0, 5, 8'h40, 3, 0);
        tick("t1.s1");
        tick("t1.s2");
        chk("t1.idle", int'(intack_all_o), 0);

        // T2: masking and mask raise withdrawal
        drive(1, 3, 8'h21, 3, 0);
        tick("t2.masked");
        chk("t2.noreq", int'(int_req_o), 0);
        drive(1, 3, 8'h21, 2, 0);
        tick("t2.unmask");
        chk("t2.req", int'(int_req_o), 1);
        drive(1, 3, 8'h21, 7, 0);
        tick("t2.raise");
        chk("t2.noclr", int'(clr_vld_o), 0);

        // T3: NMI through full mask
        drive(1, 16, 8'h0B, 15, 0);
        tick("t3.req");
        chk("t3.lvl16", int'(int_level_o), 16);
        drive(1, 16, 8'h0B, 15, 1);
        tick("t3.ack");
        chk("t3.clr0b", int'(clr_vec_o), 8'h0B);
        drive(0, 0, 0, 15, 0);
        tick("t3.s1");
        tick("t3.s2");

        // T4: higher request while presenting
        drive(1, 4, 8'h41, 0, 0);
        tick("t4.req");
        drive(1, 9, 8'h50, 0, 0);
        tick("t4.switch");
        chk("t4.vec", int'(int_vec_o), PRE ? 8'h50 : 8'h41);
        drive(1, 9, 8'h50, 0, 1);
        tick("t4.ack");
        chk("t4.clrvec", int'(clr_vec_o), PRE ? 8'h50 : 8'h41);
        drive(1, 9, 8'h50, 0, 0);
        tick("t4.s1");
        tick("t4.s2");
        tick("t4.again");
        chk("t4.vec50", int'(int_vec_o), 8'h50);
        drive(0, 9, 8'h50, 0, 0);
        tick("t4.drop");

        // T5: ack and withdrawal together
        drive(1, 6, 8'h22, 0, 0);
        tick("t5.req");
        drive(0, 6, 8'h22, 0, 1);
        tick("t5.ack");
        chk("t5.clr", int'(clr_vld_o), 1);
        chk("t5.clr22", int'(clr_vec_o), 8'h22);
        drive(1, 5, 8'h33, 3, 0);

        // T6: async reset in SETTLE, release with request pending
        tick("t6.settle");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t6.async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick("t6.rel");
        chk("t6.req", int'(int_req_o), 1);
        chk("t6.vec33", int'(int_vec_o), 8'h33);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 16),
                  $urandom_range(0, 255), $urandom_range(0, 15),
                  ($urandom_range(0, 3) == 0));
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
